// File: rtl/f2c_stream_arb.sv
// Round-robin, burst-granular arbiter sharing the FPGA->CPU DMA stream among NUM_SRC sources.
// Optional per-source beat counters are enabled with `define F2C_ARB_STATS_EN.
module f2c_stream_arb #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                         pcieClk_in,
  input  logic                         pcieRstN_in,
  input  logic                         f2cReset_in,
  input  logic [BURST_WIDTH-1:0]       burstLen_in,
  input  logic [NUM_SRC-1:0]           srcEnable_in,
  input  logic [NUM_SRC-1:0][63:0]     srcData_in,
  input  logic [NUM_SRC-1:0]           srcValid_in,
  output logic [NUM_SRC-1:0]           srcReady_out,
  output logic [63:0]                  f2cData_out,
  output logic                         f2cValid_out,
  input  logic                         f2cReady_in,
  output logic [$clog2(NUM_SRC)-1:0]   grant_out,
  output logic                         busy_out
`ifdef F2C_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_SRC)-1:0]   statSel_in,
  output logic [31:0]                  statData_out
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);

  typedef enum logic {StArb, StStream} state_e;

  state_e               state;
  logic [IdxW-1:0]      ptr;
  logic [IdxW-1:0]      grant;
  logic [BURST_WIDTH-1:0] cnt;
  logic [BURST_WIDTH-1:0] len;

  logic [NUM_SRC-1:0]   cands;
  logic                 found;
  logic [IdxW-1:0]      pick;
  logic [IdxW-1:0]      candIdx;
  logic [IdxW-1:0]      nextPtr;
  logic                 grantEn;
  logic                 accept;
  logic                 lastBeat;

  assign cands = srcEnable_in & srcValid_in;

  // First candidate at or above ptr, wrapping modulo NUM_SRC.
  always_comb begin
    found   = 1'b0;
    pick    = ptr;
    candIdx = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      candIdx = IdxW'((int'(ptr) + i) % NUM_SRC);
      if (!found && cands[candIdx]) begin
        found = 1'b1;
        pick  = candIdx;
      end
    end
  end

  assign grantEn  = srcEnable_in[grant];
  assign nextPtr  = (grant == IdxW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
  assign accept   = f2cValid_out & f2cReady_in;
  assign lastBeat = accept && (cnt == len - BURST_WIDTH'(1));

  always_comb begin
    srcReady_out = '0;
    f2cData_out  = srcData_in[grant];
    f2cValid_out = 1'b0;
    if (state == StStream) begin
      f2cValid_out        = srcValid_in[grant] & grantEn;
      srcReady_out[grant] = f2cReady_in & grantEn;
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state    <= StArb;
      ptr      <= '0;
      grant    <= '0;
      cnt      <= '0;
      len      <= '0;
      busy_out <= 1'b0;
    end else if (f2cReset_in) begin
      state    <= StArb;
      ptr      <= '0;
      grant    <= '0;
      cnt      <= '0;
      len      <= '0;
      busy_out <= 1'b0;
    end else begin
      unique case (state)
        StArb: begin
          if (found) begin
            grant    <= pick;
            len      <= burstLen_in;
            cnt      <= '0;
            state    <= StStream;
            busy_out <= 1'b1;
          end
        end
        StStream: begin
          // A disabled source forfeits the rest of its burst.
          if (!grantEn || lastBeat) begin
            state    <= StArb;
            busy_out <= 1'b0;
            ptr      <= nextPtr;
          end else if (accept) begin
            cnt <= cnt + BURST_WIDTH'(1);
          end
        end
        default: state <= StArb;
      endcase
    end
  end

  assign grant_out = grant;

`ifdef F2C_ARB_STATS_EN
  // Sized to a power of two so any statSel_in value reads a defined (zero) entry.
  logic [31:0] statCnt [2**IdxW];

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      for (int i = 0; i < 2**IdxW; i++) statCnt[i] <= '0;
      statData_out <= '0;
    end else if (f2cReset_in) begin
      for (int i = 0; i < 2**IdxW; i++) statCnt[i] <= '0;
      statData_out <= '0;
    end else begin
      if (accept) statCnt[grant] <= statCnt[grant] + 32'd1;
      statData_out <= statCnt[statSel_in];
    end
  end
`endif

endmodule

// File: tb/tb_f2c_stream_arb.sv
// Directed self-checking bench for f2c_stream_arb (NUM_SRC=4, BURST_WIDTH=4).
module tb_f2c_stream_arb;

  localparam int unsigned NumSrc = 4;
  localparam int unsigned Bw     = 4;

  logic                    pcieClk = 1'b0;
  logic                    pcieRstN;
  logic                    f2cReset;
  logic [Bw-1:0]           burstLen;
  logic [NumSrc-1:0]       srcEnable;
  logic [NumSrc-1:0][63:0] srcData;
  logic [NumSrc-1:0]       srcValid;
  logic [NumSrc-1:0]       srcReady;
  logic [63:0]             f2cData;
  logic                    f2cValid;
  logic                    f2cReady;
  logic [1:0]              grant;
  logic                    busy;
`ifdef F2C_ARB_STATS_EN
  logic [1:0]              statSel = 2'd0;
  logic [31:0]             statData;
`endif

  int nChecks = 0;
  int nPass   = 0;
  int acc;

  always #5 pcieClk = ~pcieClk;

  f2c_stream_arb #(
    .NUM_SRC     (NumSrc),
    .BURST_WIDTH (Bw)
  ) dut (
    .pcieClk_in   (pcieClk),
    .pcieRstN_in  (pcieRstN),
    .f2cReset_in  (f2cReset),
    .burstLen_in  (burstLen),
    .srcEnable_in (srcEnable),
    .srcData_in   (srcData),
    .srcValid_in  (srcValid),
    .srcReady_out (srcReady),
    .f2cData_out  (f2cData),
    .f2cValid_out (f2cValid),
    .f2cReady_in  (f2cReady),
    .grant_out    (grant),
    .busy_out     (busy)
`ifdef F2C_ARB_STATS_EN
    ,
    .statSel_in   (statSel),
    .statData_out (statData)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pcieClk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_grant"}, grant, 2'd0);
    check({tag, "_valid"}, f2cValid, 1'b0);
    check({tag, "_ready"}, srcReady, 4'b0000);
`ifdef F2C_ARB_STATS_EN
    check({tag, "_stat"}, statData, 32'd0);
`endif
  endtask

  // Backpressure vectors: cycle 0 is the ARB cycle, 1..7 stream, 8 back in ARB.
  logic bpValid [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic bpReady [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic bpBusy  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pcieRstN  = 1'b0;
    f2cReset  = 1'b0;
    burstLen  = '0;
    srcEnable = '0;
    srcValid  = '0;
    f2cReady  = 1'b0;
    for (int i = 0; i < NumSrc; i++) srcData[i] = 64'hD0D0_0000_0000_0000 + 64'(i);

    #12;
    checkIdle("reset");
    @(posedge pcieClk);
    #1;
    pcieRstN = 1'b1;
    tick();

    // Single source 2, bursts of 4: ARB, 4 beats, ARB, 4 beats.
    burstLen  = 4'd4;
    srcEnable = 4'b0100;
    srcValid  = 4'b0100;
    f2cReady  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("single_busy", busy, (k % 5) != 0);
      if ((k % 5) != 0) begin
        check("single_grant", grant, 2'd2);
        check("single_data", f2cData, 64'hD0D0_0000_0000_0002);
        check("single_ready", srcReady, 4'b0100);
      end
      tick();
    end
    srcValid  = '0;
    srcEnable = '0;
    tick();

    // Pointer is now 3; soft reset mid-burst must send it back to 0.
    srcEnable = 4'hF;
    srcValid  = 4'hF;
    burstLen  = 4'd2;
    #1;
    check("pre_soft_busy", busy, 1'b0);
    tick();
    check("pre_soft_grant", grant, 2'd3);
    check("pre_soft_busy2", busy, 1'b1);
    f2cReset = 1'b1;
    tick();
    f2cReset = 1'b0;
    checkIdle("softrst");

    // Round robin 0,1,2,3,0 with 2 beats each and one dead cycle between.
    for (int k = 0; k < 15; k++) begin
      #1;
      check("rr_busy", busy, (k % 3) != 0);
      if ((k % 3) != 0) begin
        check("rr_grant", grant, 64'((k / 3) % 4));
        check("rr_data", f2cData, 64'hD0D0_0000_0000_0000 + 64'((k / 3) % 4));
        check("rr_ready", srcReady, 64'(1 << ((k / 3) % 4)));
        check("rr_valid", f2cValid, 1'b1);
      end
      tick();
    end
    srcValid  = '0;
    srcEnable = '0;
    tick();

    // Backpressure and a 2-cycle valid gap on source 0, burst of 3.
    srcEnable = 4'b0001;
    burstLen  = 4'd3;
    acc       = 0;
    for (int c = 0; c < 9; c++) begin
      srcValid = {3'b000, bpValid[c]};
      f2cReady = bpReady[c];
      #1;
      check("bp_busy", busy, bpBusy[c]);
      check("bp_valid", f2cValid, bpBusy[c] & bpValid[c]);
      check("bp_ready", srcReady, {3'b000, bpBusy[c] & bpReady[c]});
      if (f2cValid && f2cReady) acc++;
      tick();
    end
    check("bp_beats", acc, 3);
    srcValid = '0;

    // burstLen 0 means 2**4 = 16 beats.
    burstLen  = 4'd0;
    srcEnable = 4'b0010;
    srcValid  = 4'b0010;
    f2cReady  = 1'b1;
    acc       = 0;
    for (int k = 0; k < 17; k++) begin
      #1;
      if (busy && f2cValid && f2cReady) acc++;
      tick();
    end
    check("wrap_beats", acc, 16);
    check("wrap_release", busy, 1'b0);
    srcValid = '0;
    tick();

    // Disable source 1 after 2 of 8 beats; next grant goes to source 2.
    burstLen  = 4'd8;
    srcEnable = 4'b0110;
    srcValid  = 4'b0010;
    #1;
    check("dis_arb", busy, 1'b0);
    tick();
    check("dis_grant1", grant, 2'd1);
    tick();
    tick();
    srcEnable = 4'b0100;
    srcValid  = 4'b0110;
    #1;
    check("dis_valid_masked", f2cValid, 1'b0);
    check("dis_ready_masked", srcReady, 4'b0000);
    check("dis_still_busy", busy, 1'b1);
    tick();
    check("dis_back_arb", busy, 1'b0);
    tick();
    check("dis_next_busy", busy, 1'b1);
    check("dis_next_grant", grant, 2'd2);

    // Asynchronous reset mid-burst, then search restarts at source 0.
    #1;
    pcieRstN = 1'b0;
    #1;
    checkIdle("asyncrst");
    @(posedge pcieClk);
    #1;
    pcieRstN  = 1'b1;
    srcEnable = 4'hF;
    srcValid  = 4'hF;
    #1;
    check("post_rst_arb", busy, 1'b0);
    tick();
    check("post_rst_busy", busy, 1'b1);
    check("post_rst_grant", grant, 2'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
